// File: rtl/kbd_seq_ctrl_if.sv
// Purpose: bundles the sequencer's byte input, ROM, key buffer, reader and key-status signals.
// Latency: none, wiring only.
// Backpressure: in_ready gates the byte stream; rd_gnt stalls the display reader.
// Ports: in_valid/in_data/in_ready (byte input), rom_addr/rom_data (lookup ROM),
//        mem_we/mem_addr/mem_wdata/mem_rdata (key buffer), rd_req/rd_addr/rd_gnt/
//        rd_data/rd_dvalid (display reader), key_down/key_code/key_ascii/press_cnt (status).
//        master = controller side, slave = surrounding datapath / environment.
interface kbd_seq_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [7:0]        rom_addr;
  logic [7:0]        rom_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [7:0]        rd_data;
  logic              rd_dvalid;
  logic              key_down;
  logic [7:0]        key_code;
  logic [7:0]        key_ascii;
  logic [7:0]        press_cnt;

  modport master (
    input  in_valid, in_data, rom_data, mem_rdata, rd_req, rd_addr,
    output in_ready, rom_addr, mem_we, mem_addr, mem_wdata,
           rd_gnt, rd_data, rd_dvalid, key_down, key_code, key_ascii, press_cnt
  );

  modport slave (
    output in_valid, in_data, rom_data, mem_rdata, rd_req, rd_addr,
    input  in_ready, rom_addr, mem_we, mem_addr, mem_wdata,
           rd_gnt, rd_data, rd_dvalid, key_down, key_code, key_ascii, press_cnt
  );
endinterface

// File: rtl/kbd_seq_ctrl.sv
// Purpose: PS/2 scancode sequencer: decodes make/break/extended, looks up ASCII, writes key buffer.
// Latency: make byte accepted in T, key buffer write in T+2, next byte accepted in T+3.
// Backpressure: in_ready low during LOOKUP/WRITE; reader denied only in a write cycle.
// Ports: clk, rst (sync, active high), bus (kbd_seq_ctrl_if.master; see interface header).
// Option: define KBD_REPEAT_FILTER_EN to drop typematic repeats of the held key in IDLE.
module kbd_seq_ctrl #(
  parameter int         ADDR_W     = 8,
  parameter logic [7:0] BREAK_CODE = 8'hF0,
  parameter logic [7:0] EXT_CODE   = 8'hE0
) (
  input  logic          clk,
  input  logic          rst,
  kbd_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              brk_q, brk_d;
  logic              ext_q, ext_d;
  logic [7:0]        code_q, code_d;
  logic              key_down_q, key_down_d;
  logic [7:0]        key_code_q, key_code_d;
  logic [7:0]        key_ascii_q, key_ascii_d;
  logic [7:0]        press_cnt_q, press_cnt_d;
  logic              rd_dvalid_q, rd_dvalid_d;

  logic accept;
  logic writing;
  logic repeat_hit;
  logic rd_gnt_c;

  assign accept  = bus.in_valid && (state_q == IDLE) && !rst;
  // A WRITE cycle with an unmapped code leaves the port free for the reader.
  assign writing = (state_q == WRITE) && (bus.rom_data != 8'h00);
  assign rd_gnt_c = bus.rd_req && !writing && !rst;

`ifdef KBD_REPEAT_FILTER_EN
  assign repeat_hit = key_down_q && (bus.in_data == key_code_q);
`else
  assign repeat_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      code_q      <= 8'h00;
      key_down_q  <= 1'b0;
      key_code_q  <= 8'h00;
      key_ascii_q <= 8'h00;
      press_cnt_q <= 8'h00;
      rd_dvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      code_q      <= code_d;
      key_down_q  <= key_down_d;
      key_code_q  <= key_code_d;
      key_ascii_q <= key_ascii_d;
      press_cnt_q <= press_cnt_d;
      rd_dvalid_q <= rd_dvalid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    code_d      = code_q;
    key_down_d  = key_down_q;
    key_code_d  = key_code_q;
    key_ascii_d = key_ascii_q;
    press_cnt_d = press_cnt_q;
    rd_dvalid_d = rd_gnt_c;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_data == EXT_CODE) begin
            ext_d = 1'b1;
          end else if (bus.in_data == BREAK_CODE) begin
            brk_d = 1'b1;
          end else if (brk_q) begin
            // Extended releases never match: extended keys are never held.
            if (!ext_q && (bus.in_data == key_code_q)) begin
              key_down_d = 1'b0;
              key_code_d = 8'h00;
            end
            brk_d = 1'b0;
            ext_d = 1'b0;
          end else if (ext_q) begin
            ext_d = 1'b0;
          end else if (!repeat_hit) begin
            code_d  = bus.in_data;
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        state_d = WRITE;
      end
      WRITE: begin
        if (writing) begin
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          press_cnt_d = press_cnt_q + 8'd1;
          key_ascii_d = bus.rom_data;
          key_code_d  = code_q;
          key_down_d  = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.rom_addr  = code_q;
    bus.mem_we    = writing && !rst;
    bus.mem_addr  = writing ? wr_ptr_q : bus.rd_addr;
    bus.mem_wdata = bus.rom_data;
    bus.rd_gnt    = rd_gnt_c;
    bus.rd_data   = bus.mem_rdata;
    bus.rd_dvalid = rd_dvalid_q;
    bus.key_down  = key_down_q;
    bus.key_code  = key_code_q;
    bus.key_ascii = key_ascii_q;
    bus.press_cnt = press_cnt_q;
  end

endmodule
